// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module  : cpu_datapath
// Brief   : 32-bit single-bus CPU datapath slice with register file and ALU.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r2_in,
  input  logic             r4_in,
  input  logic             r5_in,
  input  logic             r2out,
  input  logic             r4out,
  input  logic             PC_in,
  input  logic             PCout,
  input  logic             Inc_PC,
  input  logic             read,
  input  logic             IR_in,
  input  logic             Y_in,
  input  logic             Z_in,
  input  logic             MAR_in,
  input  logic             MDR_in,
  input  logic             ZLOWout,
  input  logic             MDRout,
  input  logic             inPort_in,
  input  logic [4:0]       ALU_select,
  input  logic [WIDTH-1:0] MdataIn,
  output logic [WIDTH-1:0] ALU_out
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_SHR = 5'b00010;
  localparam logic [4:0] OP_SHL = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00101;
  localparam logic [4:0] OP_ROR = 5'b00110;
  localparam logic [4:0] OP_ROL = 5'b00111;
  localparam logic [4:0] OP_NEG = 5'b01000;
  localparam logic [4:0] OP_NOT = 5'b01001;
  localparam logic [4:0] OP_MUL = 5'b01010;

  logic [WIDTH-1:0]   pc_q, ir_q, y_q, mar_q, mdr_q, inport_q, r2_q, r4_q, r5_q;
  logic [2*WIDTH-1:0] z_q;
  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   mdr_d;
  logic [2*WIDTH-1:0] c_d;
  logic [2*WIDTH-1:0] mul_a, mul_b;
  logic [SHW-1:0]     sh;

  // Fixed priority keeps the bus deterministic if control ever overlaps.
  always_comb begin
    bus = '0;
    if (MDRout)       bus = mdr_q;
    else if (ZLOWout) bus = z_q[WIDTH-1:0];
    else if (PCout)   bus = pc_q;
    else if (r2out)   bus = r2_q;
    else if (r4out)   bus = r4_q;
  end

  assign sh    = bus[SHW-1:0];
  assign mul_a = {{WIDTH{y_q[WIDTH-1]}}, y_q};
  assign mul_b = {{WIDTH{bus[WIDTH-1]}}, bus};

  always_comb begin
    c_d = '0;
    if (Inc_PC) begin
      c_d[WIDTH-1:0] = bus + ONE;
    end else begin
      case (ALU_select)
        OP_ADD: c_d[WIDTH-1:0] = y_q + bus;
        OP_SUB: c_d[WIDTH-1:0] = y_q - bus;
        OP_SHR: c_d[WIDTH-1:0] = y_q >> sh;
        OP_SHL: c_d[WIDTH-1:0] = y_q << sh;
        OP_AND: c_d[WIDTH-1:0] = y_q & bus;
        OP_OR:  c_d[WIDTH-1:0] = y_q | bus;
        // A shift by WIDTH yields zero, so a zero rotate amount returns A intact.
        OP_ROR: c_d[WIDTH-1:0] = (y_q >> sh) | (y_q << (WIDTH - int'(sh)));
        OP_ROL: c_d[WIDTH-1:0] = (y_q << sh) | (y_q >> (WIDTH - int'(sh)));
        OP_NEG: c_d[WIDTH-1:0] = '0 - bus;
        OP_NOT: c_d[WIDTH-1:0] = ~bus;
        OP_MUL: c_d = mul_a * mul_b;
        default: c_d = '0;
      endcase
    end
  end

  assign ALU_out = c_d[WIDTH-1:0];
  assign mdr_d   = read ? MdataIn : bus;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      y_q      <= '0;
      z_q      <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      inport_q <= '0;
      r2_q     <= '0;
      r4_q     <= '0;
      r5_q     <= '0;
    end else begin
      if (PC_in)     pc_q     <= bus;
      if (IR_in)     ir_q     <= bus;
      if (Y_in)      y_q      <= bus;
      if (Z_in)      z_q      <= c_d;
      if (MAR_in)    mar_q    <= bus;
      if (MDR_in)    mdr_q    <= mdr_d;
      if (inPort_in) inport_q <= bus;
      if (r2_in)     r2_q     <= bus;
      if (r4_in)     r4_q     <= bus;
      if (r5_in)     r5_q     <= bus;
    end
  end

  // These registers feed downstream blocks outside this slice.
  logic unused_state;
  assign unused_state = ^{ir_q, mar_q, inport_q, r5_q, z_q[2*WIDTH-1:WIDTH]};

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_datapath
// Brief   : Directed, table-driven self-checking bench for cpu_datapath.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        r2_in, r4_in, r5_in, r2out, r4out, PC_in, PCout, Inc_PC, read;
  logic        IR_in, Y_in, Z_in, MAR_in, MDR_in, ZLOWout, MDRout, inPort_in;
  logic [4:0]  ALU_select;
  logic [31:0] MdataIn;
  logic [31:0] ALU_out;

  int tests  = 0;
  int errors = 0;

  cpu_datapath #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .r2_in(r2_in), .r4_in(r4_in), .r5_in(r5_in),
    .r2out(r2out), .r4out(r4out),
    .PC_in(PC_in), .PCout(PCout), .Inc_PC(Inc_PC), .read(read),
    .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .MAR_in(MAR_in), .MDR_in(MDR_in),
    .ZLOWout(ZLOWout), .MDRout(MDRout), .inPort_in(inPort_in),
    .ALU_select(ALU_select), .MdataIn(MdataIn), .ALU_out(ALU_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        inc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_c;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    {r2_in, r4_in, r5_in, r2out, r4out, PC_in, PCout, Inc_PC, read} = '0;
    {IR_in, Y_in, Z_in, MAR_in, MDR_in, ZLOWout, MDRout, inPort_in} = '0;
    ALU_select = 5'b0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    clear_ctrl();
    MdataIn = v; read = 1'b1; MDR_in = 1'b1;
    step();
    clear_ctrl();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"},  {32'b0, dut.pc_q},     64'h0);
    check({tag, "_ir"},  {32'b0, dut.ir_q},     64'h0);
    check({tag, "_y"},   {32'b0, dut.y_q},      64'h0);
    check({tag, "_z"},   dut.z_q,               64'h0);
    check({tag, "_mar"}, {32'b0, dut.mar_q},    64'h0);
    check({tag, "_mdr"}, {32'b0, dut.mdr_q},    64'h0);
    check({tag, "_inp"}, {32'b0, dut.inport_q}, 64'h0);
    check({tag, "_r2"},  {32'b0, dut.r2_q},     64'h0);
    check({tag, "_r4"},  {32'b0, dut.r4_q},     64'h0);
    check({tag, "_r5"},  {32'b0, dut.r5_q},     64'h0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"add",      5'b00000, 1'b0, 32'hF0000001, 32'h00000004, 64'h00000000_F0000005});
    vecs.push_back('{"sub",      5'b00001, 1'b0, 32'hF0000001, 32'h00000004, 64'h00000000_EFFFFFFD});
    vecs.push_back('{"shr",      5'b00010, 1'b0, 32'hF0000001, 32'h00000004, 64'h00000000_0F000000});
    vecs.push_back('{"shl",      5'b00011, 1'b0, 32'hF0000001, 32'h00000004, 64'h00000000_00000010});
    vecs.push_back('{"and",      5'b00100, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 64'h00000000_0F000F00});
    vecs.push_back('{"or",       5'b00101, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 64'h00000000_FF0FFF0F});
    vecs.push_back('{"ror",      5'b00110, 1'b0, 32'hF0000001, 32'h00000004, 64'h00000000_1F000000});
    vecs.push_back('{"rol",      5'b00111, 1'b0, 32'hF0000001, 32'h00000004, 64'h00000000_0000001F});
    vecs.push_back('{"neg",      5'b01000, 1'b0, 32'hF0000001, 32'h00000004, 64'h00000000_FFFFFFFC});
    vecs.push_back('{"not",      5'b01001, 1'b0, 32'hF0000001, 32'h00000004, 64'h00000000_FFFFFFFB});
    vecs.push_back('{"mul_neg",  5'b01010, 1'b0, 32'hF0000001, 32'h00000004, 64'hFFFFFFFF_C0000004});
    vecs.push_back('{"mul_pos",  5'b01010, 1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000});
    vecs.push_back('{"bad_op",   5'b01011, 1'b0, 32'hF0000001, 32'h00000004, 64'h0});
    vecs.push_back('{"bad_op31", 5'b11111, 1'b0, 32'hF0000001, 32'h00000004, 64'h0});
    vecs.push_back('{"ror_0",    5'b00110, 1'b0, 32'hF0000001, 32'h00000020, 64'h00000000_F0000001});
    vecs.push_back('{"rol_0",    5'b00111, 1'b0, 32'hF0000001, 32'h00000000, 64'h00000000_F0000001});
    vecs.push_back('{"shl_0",    5'b00011, 1'b0, 32'hF0000001, 32'h00000020, 64'h00000000_F0000001});
    vecs.push_back('{"shr_31",   5'b00010, 1'b0, 32'h80000000, 32'h0000001F, 64'h00000000_00000001});
    vecs.push_back('{"sub_wrap", 5'b00001, 1'b0, 32'h00000000, 32'h00000001, 64'h00000000_FFFFFFFF});
    vecs.push_back('{"add_wrap", 5'b00000, 1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h0});
    vecs.push_back('{"inc_mul",  5'b01010, 1'b1, 32'hF0000001, 32'h00000004, 64'h00000000_00000005});

    clear_ctrl();
    MdataIn = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_all_zero("rst");

    // Register init through MDR
    load_mdr(32'h22); MDRout = 1'b1; r2_in = 1'b1; step(); clear_ctrl();
    load_mdr(32'h24); MDRout = 1'b1; r4_in = 1'b1; step(); clear_ctrl();
    load_mdr(32'h26); MDRout = 1'b1; r5_in = 1'b1; step(); clear_ctrl();
    check("init_r2", {32'b0, dut.r2_q}, 64'h22);
    check("init_r4", {32'b0, dut.r4_q}, 64'h24);
    check("init_r5", {32'b0, dut.r5_q}, 64'h26);

    // and R5, R2, R4
    r2out = 1'b1; Y_in = 1'b1; step(); clear_ctrl();
    check("and_y", {32'b0, dut.y_q}, 64'h22);
    r4out = 1'b1; ALU_select = 5'b00100; Z_in = 1'b1; #1;
    check("and_aluout", {32'b0, ALU_out}, 64'h20);
    step(); clear_ctrl();
    check("and_z", dut.z_q, 64'h20);
    ZLOWout = 1'b1; r5_in = 1'b1; step(); clear_ctrl();
    check("and_r5", {32'b0, dut.r5_q}, 64'h20);

    // Fetch: PC -> MAR, PC+1 -> Z -> PC, MDR -> IR
    PCout = 1'b1; MAR_in = 1'b1; Z_in = 1'b1; Inc_PC = 1'b1; step(); clear_ctrl();
    check("fetch_mar", {32'b0, dut.mar_q}, 64'h0);
    check("fetch_z",   dut.z_q,            64'h1);
    ZLOWout = 1'b1; PC_in = 1'b1; MDR_in = 1'b1; read = 1'b0; MdataIn = 32'hDEAD; step(); clear_ctrl();
    check("fetch_pc",  {32'b0, dut.pc_q},  64'h1);
    check("fetch_mdr", {32'b0, dut.mdr_q}, 64'h1);
    MDRout = 1'b1; IR_in = 1'b1; step(); clear_ctrl();
    check("fetch_ir",  {32'b0, dut.ir_q},  64'h1);

    // Bus priority with overlapping out-enables (MDR=1, Z=1, PC=1, R2=0x22, R4=0x24)
    ALU_select = 5'b01001;
    MDRout = 1'b1; r2out = 1'b1; r4out = 1'b1; #1;
    check("prio_mdr", {32'b0, ALU_out}, 64'hFFFFFFFE);
    MDRout = 1'b0; PCout = 1'b1; #1;
    check("prio_pc", {32'b0, ALU_out}, 64'hFFFFFFFE);
    PCout = 1'b0; #1;
    check("prio_r2", {32'b0, ALU_out}, 64'hFFFFFFDD);
    r2out = 1'b0; #1;
    check("prio_r4", {32'b0, ALU_out}, 64'hFFFFFFDB);
    clear_ctrl();

    // Same register as source and destination keeps a clean old-value capture
    r2out = 1'b1; r2_in = 1'b1; Y_in = 1'b1; step(); clear_ctrl();
    check("self_r2", {32'b0, dut.r2_q}, 64'h22);

    // ALU sweep: Y <- a, MDR <- b, then Z <- op(Y, bus)
    for (int i = 0; i < vecs.size(); i++) begin
      load_mdr(vecs[i].a);
      MDRout = 1'b1; Y_in = 1'b1; step(); clear_ctrl();
      load_mdr(vecs[i].b);
      MDRout = 1'b1; ALU_select = vecs[i].op; Inc_PC = vecs[i].inc; Z_in = 1'b1; #1;
      check({vecs[i].name, "_out"}, {32'b0, ALU_out}, {32'b0, vecs[i].exp_c[31:0]});
      step(); clear_ctrl();
      check({vecs[i].name, "_z"}, dut.z_q, vecs[i].exp_c);
    end

    // Reset during a Z-load step wins over every enable
    load_mdr(32'h11);
    MDRout = 1'b1; ALU_select = 5'b00000; Z_in = 1'b1; Y_in = 1'b1; r2_in = 1'b1;
    PC_in = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; clear_ctrl();
    check_all_zero("midrst");

    // No-enable cycle: bus is zero and everything holds
    load_mdr(32'h55);
    MDRout = 1'b1; r2_in = 1'b1; step(); clear_ctrl();
    ALU_select = 5'b01001; MdataIn = 32'hAAAA; #1;
    check("idle_bus", {32'b0, ALU_out}, 64'hFFFFFFFF);
    step();
    check("idle_r2",  {32'b0, dut.r2_q},  64'h55);
    check("idle_mdr", {32'b0, dut.mdr_q}, 64'h55);
    check("idle_y",   {32'b0, dut.y_q},   64'h0);
    check("idle_z",   dut.z_q,            64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
